uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-level command parser between the UART receiver/transmitter cores and the Basys3 test-interface write ports of the TPU top level. It decodes a framed host protocol into single-cycle write strobes for the unified buffer, weight memory and instruction buffer. It also issues unified-buffer reads, pulses execution start, and serialises responses back to the UART TX core. Per-command timeouts and error responses keep the host and FPGA from desynchronising.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- `UB_RD_LATENCY`, default 1: cycles from `ub_rd_en` to valid `ub_rd_data`.

Ports:
- `clk` in 1: system clock, 100 MHz. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: one-cycle strobe, received byte on `rx_data`.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: response byte available.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: TX core accepts the byte when `tx_valid && tx_ready`.
- `ub_wr_en` out 1: UB write strobe.
- `ub_wr_addr` out 8: UB write address.
- `ub_wr_data` out 256: UB write data.
- `ub_rd_en` out 1: UB read strobe.
- `ub_rd_addr` out 8: UB read address.
- `ub_rd_data` in 256: UB read data.
- `wt_wr_en` out 1: weight write strobe.
- `wt_wr_addr` out 10: weight write address.
- `wt_wr_data` out 64: weight write data.
- `instr_wr_en` out 1: instruction write strobe.
- `instr_wr_addr` out 5: instruction write address.
- `instr_wr_data` out 32: instruction write data.
- `start_execution` out 1: one-cycle start pulse to the controller.
- `status_in` in 8: `{4'b0, wt_busy, dma_busy, vpu_busy, sys_busy}`.
- `err_pulse` out 1: one-cycle flag on any protocol error.
- `dbg_state` out 8: current FSM state encoding.
- `dbg_cmd` out 8: last opcode received.
- `dbg_byte_count` out 16: bytes received since reset, wraps at 65535 to 0.

## Operation
Frame = opcode byte, then address bytes, then data bytes. All multi-byte fields are little-endian: the first byte received maps to bits [7:0].

Commands:
- `0x01` WR_UB: 1 address byte, then 32 data bytes. Pulses `ub_wr_en`, then responds `0xAA`.
- `0x02` WR_WT: 2 address bytes (`addr[9:0]`; upper 6 bits of byte 2 ignored), then 8 data bytes. Pulses `wt_wr_en`, then responds `0xAA`.
- `0x03` WR_INSTR: 1 address byte (`addr[4:0]`), then 4 data bytes. Pulses `instr_wr_en`, then responds `0xAA`.
- `0x04` RD_UB: 1 address byte. Pulses `ub_rd_en`, waits `UB_RD_LATENCY`, captures `ub_rd_data`, then sends 32 bytes, LSB first.
- `0x05` START: pulses `start_execution`, then responds `0xAA`.
- `0x06` STATUS: responds with 1 byte, `status_in` sampled in the cycle after the opcode is received.
- Any other opcode: responds `0xEE`, pulses `err_pulse`, returns to IDLE.

FSM states and `dbg_state` encodings: IDLE=0, ADDR=1, DATA=2, EXEC=3, RD_WAIT=4, TX=5.
- IDLE: a received byte is latched as the opcode into `dbg_cmd`. Next state is ADDR, EXEC or TX, depending on the opcode.
- ADDR/DATA: a down-counter tracks the remaining bytes. The data shift register fills by byte index, not by shifting past width.
- EXEC: drive the strobe for exactly one cycle.
- RD_WAIT: count `UB_RD_LATENCY` cycles, then capture the read data.
- TX: present response bytes one at a time under the `tx_valid`/`tx_ready` handshake. Return to IDLE after the last byte is accepted.

Timeout:
- An idle counter clears on every `rx_valid` and runs only in ADDR/DATA.
- When it reaches `TIMEOUT_CYCLES`: pulse `err_pulse`, discard the partial frame, go to IDLE. No response byte is sent.

Received bytes while in EXEC, RD_WAIT or TX are dropped and pulse `err_pulse`; `dbg_byte_count` still increments.

`tx_valid`/`tx_data` must stay stable until accepted. `tx_ready` held low indefinitely stalls in TX; there is no timeout in TX.

## Timing
Reset values:
- All strobes, `tx_valid` and `err_pulse` are 0.
- All address/data outputs, `dbg_*` and the counters are 0.
- State is IDLE.

Asserting reset mid-frame aborts immediately: no strobe fires and any pending TX byte is cancelled.

Latencies:
- Writes: the final data byte is accepted at cycle N. The `*_wr_en` strobe is high at N+1 and `tx_valid` (`0xAA`) rises at N+2. Address/data outputs are valid whenever the strobe is high and hold their value afterwards.
- RD_UB: the address byte arrives at N. `ub_rd_en` is high at N+1, data is captured at N+1+`UB_RD_LATENCY`, and the first `tx_valid` comes the cycle after that.
- START: the opcode arrives at N. `start_execution` is high at N+1 and `tx_valid` rises at N+2.
- STATUS/unknown: `tx_valid` rises at N+1.

Strobe exclusivity: at most one of `ub_wr_en`, `ub_rd_en`, `wt_wr_en`, `instr_wr_en`, `start_execution` is high in any cycle.

Throughput: the next frame's opcode is accepted the cycle after the last TX byte is accepted.

## Test plan
- WR_UB addr `0x05`, data bytes 0x00..0x1F → one `ub_wr_en` pulse with `ub_wr_addr`=0x05 and `ub_wr_data`=0x1F1E…0100, then TX `0xAA`.
- WR_WT bytes `02 34 FE` + `11 22 33 44 55 66 77 88` → `wt_wr_addr`=0x234, `wt_wr_data`=0x8877665544332211, then `0xAA`.
- RD_UB addr `0x05` with a UB model at latency 1; `tx_ready` toggling 1,0,0,1 → 32 bytes 0x00..0x1F in order, with data held stable while `tx_ready` is low.
- STATUS with `status_in`=0x05 → TX `0x05`. START → exactly one `start_execution` pulse, then `0xAA`.
- Opcode `0x7F` → TX `0xEE` plus `err_pulse`. WR_INSTR stopped after 2 data bytes with `TIMEOUT_CYCLES`=100 → `err_pulse` at cycle 100, no `instr_wr_en`, and the next `0x06` is parsed correctly.
- Reset asserted after 10 data bytes of WR_UB → all outputs 0 and no strobe ever fires; a full WR_UB after reset succeeds; `dbg_byte_count` restarts at 0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Host UART framing to TPU write/read strobes, start pulse and response bytes.
// Latency: write strobe at last byte +1, response at +2; RD_UB response after UB_RD_LATENCY+2.
// Backpressure: tx_valid/tx_data hold until tx_ready; bytes arriving while busy are dropped with err_pulse.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int UB_RD_LATENCY  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         ub_wr_en,
    output logic [7:0]   ub_wr_addr,
    output logic [255:0] ub_wr_data,
    output logic         ub_rd_en,
    output logic [7:0]   ub_rd_addr,
    input  logic [255:0] ub_rd_data,
    output logic         wt_wr_en,
    output logic [9:0]   wt_wr_addr,
    output logic [63:0]  wt_wr_data,
    output logic         instr_wr_en,
    output logic [4:0]   instr_wr_addr,
    output logic [31:0]  instr_wr_data,
    output logic         start_execution,
    input  logic [7:0]   status_in,
    output logic         err_pulse,
    output logic [7:0]   dbg_state,
    output logic [7:0]   dbg_cmd,
    output logic [15:0]  dbg_byte_count
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2,
        S_EXEC = 3'd3, S_RD_WAIT = 3'd4, S_TX = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = (UB_RD_LATENCY > 0) ? $clog2(UB_RD_LATENCY + 1) : 1;

    state_t         state;
    logic [7:0]     cmd;
    logic [9:0]     addr_sr;
    logic [255:0]   data_sr;
    logic [255:0]   data_nxt;
    logic [5:0]     rem;
    logic [4:0]     idx;
    logic [TW-1:0]  idle_cnt;
    logic [LW-1:0]  lat_cnt;
    logic [255:0]   tx_buf;
    logic [5:0]     tx_rem;
    logic [15:0]    byte_cnt;

    // Final data byte is merged combinationally so the strobe sees the complete word.
    always_comb begin
        data_nxt = data_sr;
        data_nxt[{idx, 3'b000} +: 8] = rx_data;
    end

    assign tx_valid       = (state == S_TX);
    assign tx_data        = tx_buf[7:0];
    assign dbg_state      = {5'b00000, state};
    assign dbg_cmd        = cmd;
    assign dbg_byte_count = byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cmd             <= '0;
            addr_sr         <= '0;
            data_sr         <= '0;
            rem             <= '0;
            idx             <= '0;
            idle_cnt        <= '0;
            lat_cnt         <= '0;
            tx_buf          <= '0;
            tx_rem          <= '0;
            byte_cnt        <= '0;
            ub_wr_en        <= 1'b0;
            ub_wr_addr      <= '0;
            ub_wr_data      <= '0;
            ub_rd_en        <= 1'b0;
            ub_rd_addr      <= '0;
            wt_wr_en        <= 1'b0;
            wt_wr_addr      <= '0;
            wt_wr_data      <= '0;
            instr_wr_en     <= 1'b0;
            instr_wr_addr   <= '0;
            instr_wr_data   <= '0;
            start_execution <= 1'b0;
            err_pulse       <= 1'b0;
        end else begin
            ub_wr_en        <= 1'b0;
            ub_rd_en        <= 1'b0;
            wt_wr_en        <= 1'b0;
            instr_wr_en     <= 1'b0;
            start_execution <= 1'b0;
            err_pulse       <= 1'b0;

            if (rx_valid) begin
                byte_cnt <= byte_cnt + 16'd1;
                idle_cnt <= '0;
            end else if (state == S_ADDR || state == S_DATA) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            case (state)
                S_IDLE: if (rx_valid) begin
                    cmd <= rx_data;
                    idx <= '0;
                    case (rx_data)
                        8'h01, 8'h03, 8'h04: begin rem <= 6'd1; state <= S_ADDR; end
                        8'h02: begin rem <= 6'd2; state <= S_ADDR; end
                        8'h05: begin start_execution <= 1'b1; state <= S_EXEC; end
                        8'h06: begin tx_buf <= {248'd0, status_in}; tx_rem <= 6'd1; state <= S_TX; end
                        default: begin
                            tx_buf    <= 256'hEE;
                            tx_rem    <= 6'd1;
                            err_pulse <= 1'b1;
                            state     <= S_TX;
                        end
                    endcase
                end
                S_ADDR: if (rx_valid) begin
                    if (idx[0]) addr_sr[9:8] <= rx_data[1:0];
                    else        addr_sr[7:0] <= rx_data;
                    if (rem == 6'd1) begin
                        idx <= '0;
                        case (cmd)
                            8'h01: begin rem <= 6'd32; state <= S_DATA; end
                            8'h02: begin rem <= 6'd8;  state <= S_DATA; end
                            8'h03: begin rem <= 6'd4;  state <= S_DATA; end
                            default: begin
                                ub_rd_en   <= 1'b1;
                                ub_rd_addr <= rx_data;
                                lat_cnt    <= '0;
                                state      <= S_RD_WAIT;
                            end
                        endcase
                    end else begin
                        rem <= rem - 6'd1;
                        idx <= idx + 5'd1;
                    end
                end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_pulse <= 1'b1;
                    state     <= S_IDLE;
                end
                S_DATA: if (rx_valid) begin
                    data_sr <= data_nxt;
                    if (rem == 6'd1) begin
                        state <= S_EXEC;
                        case (cmd)
                            8'h01: begin
                                ub_wr_en   <= 1'b1;
                                ub_wr_addr <= addr_sr[7:0];
                                ub_wr_data <= data_nxt;
                            end
                            8'h02: begin
                                wt_wr_en   <= 1'b1;
                                wt_wr_addr <= addr_sr;
                                wt_wr_data <= data_nxt[63:0];
                            end
                            default: begin
                                instr_wr_en   <= 1'b1;
                                instr_wr_addr <= addr_sr[4:0];
                                instr_wr_data <= data_nxt[31:0];
                            end
                        endcase
                    end else begin
                        rem <= rem - 6'd1;
                        idx <= idx + 5'd1;
                    end
                end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_pulse <= 1'b1;
                    state     <= S_IDLE;
                end
                S_EXEC: begin
                    if (rx_valid) err_pulse <= 1'b1;
                    tx_buf <= 256'hAA;
                    tx_rem <= 6'd1;
                    state  <= S_TX;
                end
                S_RD_WAIT: begin
                    if (rx_valid) err_pulse <= 1'b1;
                    if (lat_cnt == LW'(UB_RD_LATENCY)) begin
                        tx_buf <= ub_rd_data;
                        tx_rem <= 6'd32;
                        state  <= S_TX;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                S_TX: begin
                    if (rx_valid) err_pulse <= 1'b1;
                    if (tx_ready) begin
                        if (tx_rem == 6'd1) begin
                            state <= S_IDLE;
                        end else begin
                            tx_buf <= tx_buf >> 8;
                            tx_rem <= tx_rem - 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
